// File: rtl/cache_backing_memory.sv
// Byte-wide block responder behind the cache refill/write-back port.
// One request at a time: accept, wait LATENCY cycles, then stream a block
// out (refill) or absorb a block in (write-back), one byte per beat.
module cache_backing_memory #(
  parameter int MEM_DEPTH  = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        wr_done,
  output logic        busy
);

  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int BLK_W = AW - OFF;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [OFF-1:0]   LAST_BEAT = OFF'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [BLK_W-1:0] blk, blk_n;       // block index; address bits above AW alias away
  logic [OFF-1:0]   beat, beat_n;     // byte within block; never carries into blk
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             is_write, is_write_n;
  logic             wr_en;

  logic [7:0] mem [MEM_DEPTH];

  // Next-state, burst bookkeeping and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n    = state;
    blk_n      = blk;
    beat_n     = beat;
    cnt_n      = cnt;
    is_write_n = is_write;
    req_ready  = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
    busy       = 1'b1;
    wr_en      = 1'b0;

    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          blk_n      = req_addr[AW-1:OFF];
          is_write_n = req_write;
          beat_n     = '0;
          if (LATENCY == 0) begin
            state_n = req_write ? S_WRITE : S_READ;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = is_write ? S_WRITE : S_READ;
        else           cnt_n   = cnt - 1'b1;
      end
      S_READ: begin
        rd_valid = 1'b1;
        rd_last  = (beat == LAST_BEAT);
        beat_n   = beat + 1'b1;
        if (beat == LAST_BEAT) state_n = S_IDLE;
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_en  = 1'b1;
          beat_n = beat + 1'b1;
          if (beat == LAST_BEAT) state_n = S_DONE;
        end
      end
      S_DONE: begin
        wr_done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register plus the refill byte, fetched for the beat about to be presented.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      blk      <= '0;
      beat     <= '0;
      cnt      <= '0;
      is_write <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_n;
      blk      <= blk_n;
      beat     <= beat_n;
      cnt      <= cnt_n;
      is_write <= is_write_n;
      if (state_n == S_READ) rd_data <= mem[{blk_n, beat_n}];
    end
  end

  // Write-back bytes land in the backing array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive reset, including a partial write-back.
    if (wr_en) mem[{blk, beat}] <= wr_data;
  end

endmodule

// File: tb/tb_cache_backing_memory.sv
// Randomized bench for cache_backing_memory: one instance with LATENCY=4 and
// one with LATENCY=0, compared against a flat byte-array memory model.
module tb_cache_backing_memory;

  localparam int DEPTH = 4096;
  localparam int BS    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;          // 0: LATENCY=4 instance, 1: LATENCY=0 instance
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic [7:0]  wr_data;

  logic       a_req_valid, a_wr_valid, b_req_valid, b_wr_valid;
  logic       a_req_ready, a_rd_valid, a_rd_last, a_wr_ready, a_wr_done, a_busy;
  logic       b_req_ready, b_rd_valid, b_rd_last, b_wr_ready, b_wr_done, b_busy;
  logic [7:0] a_rd_data, b_rd_data;

  logic       req_ready_m, rd_valid_m, rd_last_m, wr_ready_m, wr_done_m, busy_m;
  logic [7:0] rd_data_m;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign a_wr_valid  = wr_valid & ~sel;
  assign b_wr_valid  = wr_valid & sel;

  assign req_ready_m = sel ? b_req_ready : a_req_ready;
  assign rd_valid_m  = sel ? b_rd_valid  : a_rd_valid;
  assign rd_last_m   = sel ? b_rd_last   : a_rd_last;
  assign rd_data_m   = sel ? b_rd_data   : a_rd_data;
  assign wr_ready_m  = sel ? b_wr_ready  : a_wr_ready;
  assign wr_done_m   = sel ? b_wr_done   : a_wr_done;
  assign busy_m      = sel ? b_busy      : a_busy;

  cache_backing_memory #(.MEM_DEPTH(DEPTH), .BLOCK_SIZE(BS), .LATENCY(4)) u_dut_lat4 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write), .req_addr(req_addr),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_last(a_rd_last),
    .wr_valid(a_wr_valid), .wr_data(wr_data), .wr_ready(a_wr_ready), .wr_done(a_wr_done),
    .busy(a_busy)
  );

  cache_backing_memory #(.MEM_DEPTH(DEPTH), .BLOCK_SIZE(BS), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write), .req_addr(req_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .wr_valid(b_wr_valid), .wr_data(wr_data), .wr_ready(b_wr_ready), .wr_done(b_wr_done),
    .busy(b_busy)
  );

  logic [7:0] model [2][DEPTH];
  logic [7:0] wbuf [BS];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte index in the flat store: block-aligned base plus beat, wrapped to the depth.
  function automatic int idx(input logic [31:0] addr, input int b);
    logic [31:0] base;
    base = addr - (addr % BS);
    return int'((base + 32'(b)) % DEPTH);
  endfunction

  function automatic int lat_now();
    return sel ? 0 : 4;
  endfunction

  // Present a request and return at the falling edge just after acceptance.
  task automatic request(input logic [31:0] addr, input logic wr);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    n = 0;
    while (req_ready_m !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // mode 0: wr_valid every cycle; 1: pattern 1,0,0; 2: random. abort_at>0 resets after that many bytes.
  task automatic do_write(input logic [31:0] addr, input int mode, input int abort_at);
    int s, lat, acc, cyc, bad_wait, bad_rdy, bad_done;
    logic v;
    s = int'(sel);
    lat = lat_now();
    request(addr, 1'b1);
    bad_wait = 0;
    for (int i = 0; i < lat; i++) begin
      if (wr_ready_m !== 1'b0 || busy_m !== 1'b1 || req_ready_m !== 1'b0) bad_wait++;
      wr_valid = 1'($urandom_range(0, 1));   // must be ignored outside WRITE
      wr_data  = 8'($urandom);
      @(negedge clk);
    end
    check("wr_wait_phase", 32'(bad_wait), 32'd0);
    acc = 0; cyc = 0; bad_rdy = 0; bad_done = 0;
    while (acc < BS && cyc < 200) begin
      if (wr_ready_m !== 1'b1 || busy_m !== 1'b1) bad_rdy++;
      if (wr_done_m !== 1'b0) bad_done++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      wr_valid = v;
      wr_data  = v ? wbuf[acc] : 8'($urandom);
      @(posedge clk);
      if (v) begin
        model[s][idx(addr, acc)] = wbuf[acc];
        acc++;
      end
      cyc++;
      @(negedge clk);
      wr_valid = 1'b0;
      if (abort_at > 0 && acc == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_wr_ready", 32'(wr_ready_m), 32'd0);
        check("abort_outs", {28'd0, rd_valid_m, rd_last_m, wr_done_m, 1'b0}, 32'd0);
        check("abort_rd_data", 32'(rd_data_m), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready_m), 32'd1);
        return;
      end
    end
    check("wr_timeout", 32'(cyc < 200), 32'd1);
    check("wr_ready_in_write", 32'(bad_rdy), 32'd0);
    check("wr_done_early", 32'(bad_done), 32'd0);
    check("wr_done_pulse", {29'd0, wr_done_m, wr_ready_m, busy_m}, 32'b101);
    @(negedge clk);
    check("wr_after_done", {29'd0, wr_done_m, req_ready_m, busy_m}, 32'b010);
  endtask

  // Refill and compare every beat; poke=1 waves stray requests while busy.
  task automatic do_read(input logic [31:0] addr, input bit poke);
    int s, lat, bad_wait, bad_beat;
    s = int'(sel);
    lat = lat_now();
    request(addr, 1'b0);
    bad_wait = 0;
    for (int i = 0; i < lat; i++) begin
      if (rd_valid_m !== 1'b0 || busy_m !== 1'b1 || req_ready_m !== 1'b0) bad_wait++;
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = addr ^ 32'h0000_0340;
      end
      @(negedge clk);
    end
    check("rd_wait_phase", 32'(bad_wait), 32'd0);
    bad_beat = 0;
    for (int b = 0; b < BS; b++) begin
      if (rd_valid_m !== 1'b1 || req_ready_m !== 1'b0 || busy_m !== 1'b1) bad_beat++;
      if (rd_last_m !== 1'(b == BS - 1)) bad_beat++;
      check($sformatf("rd_data[%0d]", b), 32'(rd_data_m), 32'(model[s][idx(addr, b)]));
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = addr ^ 32'h0000_0560;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("rd_beat_flags", 32'(bad_beat), 32'd0);
    check("rd_after_burst", {29'd0, rd_valid_m, req_ready_m, busy_m}, 32'b010);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_a_outs", {26'd0, a_rd_valid, a_rd_last, a_wr_ready, a_wr_done, a_busy, 1'b0}, 32'd0);
    check("rst_b_outs", {26'd0, b_rd_valid, b_rd_last, b_wr_ready, b_wr_done, b_busy, 1'b0}, 32'd0);
    check("rst_a_rd_data", 32'(a_rd_data), 32'd0);
    check("rst_b_rd_data", 32'(b_rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {30'd0, a_req_ready, b_req_ready}, 32'b11);

    // Give every byte of both stores a known value.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int blk = 0; blk < DEPTH / BS; blk++) begin
        for (int i = 0; i < BS; i++) wbuf[i] = 8'($urandom);
        do_write(32'(blk * BS), 0, 0);
      end
    end

    // Write-back then refill on the LATENCY=4 instance.
    sel = 1'b0;
    for (int i = 0; i < BS; i++) wbuf[i] = 8'(8'hA0 + i);
    do_write(32'h0000_0120, 0, 0);
    do_read(32'h0000_012C, 1'b0);
    check("refill_first_byte", 32'(model[0][idx(32'h0000_012C, 0)]), 32'hA0);

    // LATENCY=0 refill timing.
    sel = 1'b1;
    for (int i = 0; i < BS; i++) wbuf[i] = 8'($urandom);
    do_write(32'h0000_0200, 0, 0);
    do_read(32'h0000_0207, 1'b0);

    // Bubbly write-back on both latencies.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < BS; i++) wbuf[i] = 8'(i);
      do_write(32'h0000_0040, 1, 0);
      do_read(32'h0000_0040, 1'b0);
    end

    // Wrap: an address above the depth aliases onto the low block.
    sel = 1'b0;
    for (int i = 0; i < BS; i++) wbuf[i] = 8'h55;
    do_write(32'h0000_1010, 0, 0);
    do_read(32'h0000_0010, 1'b0);

    // Stray requests while busy are ignored.
    do_read(32'h0000_0120, 1'b1);
    do_read(32'h0000_0120, 1'b0);

    // Reset mid write-back after 5 bytes.
    for (int i = 0; i < BS; i++) wbuf[i] = 8'($urandom);
    do_write(32'h0000_0300, 0, 5);
    do_read(32'h0000_0300, 1'b0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] a;
      sel = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 9);
      a   = $urandom;
      for (int i = 0; i < BS; i++) wbuf[i] = 8'($urandom);
      if (op < 4)       do_write(a, $urandom_range(0, 2), 0);
      else if (op == 4) do_write(a, $urandom_range(0, 2), $urandom_range(1, BS - 1));
      else              do_read(a, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_backing_memory.md
Name: cache_backing_memory

Overview:
Byte-wide main-memory responder on the far side of the direct-mapped cache's refill/write-back port. Accepts one block-granular request at a time over a valid/ready handshake, waits a programmable access latency, then streams a full block out (refill) or absorbs a full block in (write-back), one byte per beat. Used as the memory model behind the cache in system sims and as the refill target in the cache bench.

Parameters:
MEM_DEPTH, 4096, backing store size in bytes; power of two, multiple of BLOCK_SIZE.
BLOCK_SIZE, 16, bytes per burst; must match the cache's BLOCK_SIZE; power of two >= 2.
LATENCY, 4, idle cycles between request accept and first data beat; 0 allowed.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = write-back burst, 0 = refill (read) burst
req_addr  input  32  byte address; low $clog2(BLOCK_SIZE) bits ignored
rd_valid  output  1  refill beat valid
rd_data  output  8  refill byte
rd_last  output  1  final refill beat
wr_valid  input  1  write-back byte present
wr_data  input  8  write-back byte
wr_ready  output  1  responder accepting write-back bytes
wr_done  output  1  one-cycle pulse: write-back burst complete
busy  output  1  request in progress (not IDLE)

Behaviour:
- Reset (async, active-high): state IDLE, beat and latency counters 0; req_ready=1 once reset deasserts, all other outputs 0, rd_data=0. Memory array is NOT cleared by reset.
- Address mapping: base = {req_addr[31:OFF], OFF zeros}, OFF=$clog2(BLOCK_SIZE); array byte index = (base + beat) mod MEM_DEPTH. Addresses >= MEM_DEPTH alias (wrap) silently. beat never carries into the block index.
- States: IDLE, WAIT, READ, WRITE, DONE.
- IDLE: req_ready=1, busy=0. Accept on req_valid && req_ready at an edge: latch base and req_write, clear beat. Next state WAIT if LATENCY>0 (counter loaded LATENCY-1), else READ/WRITE per req_write.
- WAIT: req_ready=0, busy=1; counts down; at 0 moves to READ or WRITE. Exactly LATENCY cycles spent in WAIT.
- READ: rd_valid=1 every cycle for exactly BLOCK_SIZE consecutive cycles; no back-pressure (consumer must take every beat). rd_data = mem[base+beat], beat 0..BLOCK_SIZE-1 in ascending order. rd_last=1 only with beat BLOCK_SIZE-1. After last beat -> IDLE (req_ready high the following cycle).
- First refill beat is sampled by the consumer at accept edge + LATENCY + 1.
- WRITE: wr_ready=1; each edge with wr_valid && wr_ready writes wr_data to mem[base+beat], beat++. wr_valid low = bubble, no write, beat held; unlimited bubbles allowed. After BLOCK_SIZE-th accepted byte -> DONE. wr_valid while not in WRITE is ignored.
- DONE: wr_done=1 for exactly one cycle, wr_ready=0, busy=1; -> IDLE.
- req_valid while not IDLE is ignored (no queuing); requester must hold req_valid until accepted.
- Only one burst outstanding; back-to-back requests: next accept earliest the cycle after READ's last beat or DONE.
- Reset mid-burst: burst aborted immediately, outputs to reset values; bytes already written in a partial write-back remain in memory; remaining bytes unchanged.
- rd_data holds last value outside READ (not required to be 0 after first burst); benches check only when rd_valid=1.

Test Plan:
- Write-back then refill: LATENCY=4, write bytes 0xA0..0xAF to req_addr 0x0000_0120 -> wr_done pulses once after 16th byte; refill of 0x0000_012C returns 0xA0..0xAF in order, rd_last on 0xAF, first beat at accept edge+5.
- LATENCY=0: refill accept at edge E -> first rd_valid sampled at E+1, 16 contiguous beats, req_ready low throughout, high at E+17.
- Bubbly write-back: wr_valid toggled 1,0,0,1,... over 16 bytes 0x00..0x0F to 0x40 -> only valid bytes stored, beat stalls on bubbles, wr_done exactly once; readback 0x00..0x0F.
- Wrap: MEM_DEPTH=4096, write 0x55 block to 0x0000_1010 -> refill from 0x0000_0010 returns 0x55 block.
- Ignore while busy: pulse req_valid with a different address during WAIT/READ -> not accepted, no extra burst, req_ready stays 0.
- Reset mid write-back after 5 bytes -> outputs to reset values, IDLE; refill of that block shows 5 new bytes then old contents.
